column_cursor: RTL
==================

# column_cursor

Consumes the 2-bit command code from the PS/2 key-to-command stage (01 = right, 10 = left, 11 = drop, 00 = none) and turns it into Connect Four move actions. It maintains the column cursor and auto-repeats held arrow keys. It issues a valid/ready drop request to the game-board logic, rejects drops into full columns, and tracks which player moves next.

## Interface
- NUM_COLS, 7, number of board columns (2..8)
- REPEAT_DELAY, 25_000_000, cycles an arrow must be held before auto-repeat starts (0.5 s at 50 MHz)
- REPEAT_RATE, 10_000_000, cycles between auto-repeat steps (0.2 s)
- CLOCK_50  in  1  system clock, 50 MHz
- RESET  in  1  reset, synchronous, active-high
- KEY_TWO  in  2  command code, already registered to CLOCK_50 upstream
- COL_FULL  in  NUM_COLS  bit c high = column c has no free slot
- DROP_READY  in  1  board logic accepts a drop this cycle
- CURSOR  out  3  current column, 0..NUM_COLS-1
- DROP_VALID  out  1  drop request pending
- DROP_COL  out  3  column of pending drop; stable while DROP_VALID
- PLAYER  out  1  player to move (0/1)
- ERR_FULL  out  1  one-cycle pulse: drop rejected, column full

## Operation
- Internal registers:
  - prev: previous KEY_TWO sample
  - cnt: 26-bit repeat counter
  - state: one of IDLE, HOLD, REPEAT, DROP, WAIT_REL
- Press event: KEY_TWO != prev and KEY_TWO != 00. A direct change between nonzero codes (01 to 10, 01 to 11) is a press.
- Move operation:
  - Right: CURSOR+1. Left: CURSOR-1.
  - Behaviour at the edges (0 and NUM_COLS-1) is set by the Configuration section.
- IDLE, HOLD, REPEAT: a press event is handled first.
  - Move press: apply the move, set cnt=0, go to HOLD.
  - Drop press, COL_FULL[CURSOR]=1: pulse ERR_FULL, go to WAIT_REL.
  - Drop press, column not full: set DROP_VALID=1, latch DROP_COL=CURSOR, go to DROP.
- KEY_TWO==00 in HOLD or REPEAT: go to IDLE; cnt is cleared.
- HOLD: cnt increments each cycle. When cnt==REPEAT_DELAY-1: apply the move, set cnt=0, go to REPEAT.
- REPEAT: cnt increments each cycle. When cnt==REPEAT_RATE-1: apply the move, set cnt=0.
- DROP:
  - KEY_TWO changes are ignored; prev still tracks KEY_TWO.
  - Releasing the key does not cancel the request.
  - On DROP_VALID & DROP_READY: clear DROP_VALID, toggle PLAYER, go to WAIT_REL.
- WAIT_REL: stays until KEY_TWO==00, then goes to IDLE. The drop key never repeats.
- COL_FULL is sampled only at the drop press. Later changes do not withdraw a pending request.

## Timing
- Reset values: CURSOR=NUM_COLS/2 (3 for 7 columns), DROP_VALID=0, DROP_COL=0, PLAYER=0, ERR_FULL=0, state=IDLE, prev=00, cnt=0.
- All outputs are registered.
- A press sampled at edge N updates CURSOR, DROP_VALID or ERR_FULL at edge N, visible from cycle N+1 (latency 1).
- First auto-repeat step: REPEAT_DELAY cycles after the press step. Following steps: every REPEAT_RATE cycles.
- Handshake:
  - Transfer occurs on the edge where DROP_VALID and DROP_READY are both 1.
  - DROP_VALID falls and PLAYER toggles on that edge.
  - DROP_READY is don't-care while DROP_VALID=0.
  - DROP_READY already high when DROP_VALID rises: transfer on the next edge, so DROP_VALID is high for exactly 1 cycle.
- ERR_FULL is high for exactly one cycle per rejected press.
- RESET asserted mid-operation (any state, including a pending DROP) forces all reset values on that edge. A pending request is discarded; PLAYER does not toggle.

## Configuration
- CURSOR_WRAP_EN defined:
  - Right at NUM_COLS-1 wraps to 0; left at 0 wraps to NUM_COLS-1.
  - Applies to auto-repeat steps too.
- CURSOR_WRAP_EN undefined:
  - CURSOR saturates at 0 and NUM_COLS-1.
  - A move at the limit leaves CURSOR unchanged; state and cnt still advance as normal.

## Test plan
- Reset, then a single pulse of KEY_TWO=01 followed by 00 -> CURSOR 3 to 4 one cycle after the press; DROP_VALID=0, PLAYER=0.
- REPEAT_DELAY=10, REPEAT_RATE=4, hold 10 from CURSOR=3 for 30 cycles, no wrap -> CURSOR 2 at press, 1 at +10, 0 at +14, stays 0. With CURSOR_WRAP_EN: 6 at +18, 5 at +22, 4 at +26.
- CURSOR=3, COL_FULL=0, KEY_TWO=11, DROP_READY low for 5 cycles then high -> DROP_VALID high 6 cycles with DROP_COL=3; PLAYER 0 to 1 on the transfer edge; holding 11 afterwards gives no second request.
- COL_FULL=7'b0001000, CURSOR=3, press 11 -> ERR_FULL one-cycle pulse, DROP_VALID stays 0, PLAYER unchanged.
- Drop pending (DROP_VALID=1), assert RESET for one cycle -> DROP_VALID=0, CURSOR=3, PLAYER=0; a later DROP_READY has no effect.
- Hold 01, then switch directly to 10 -> two separate moves (net CURSOR unchanged); the repeat counter restarts from 0 on the switch.

Source files
------------

// File: rtl/column_cursor.sv
// Connect Four column cursor: turns PS/2 command codes into cursor moves with auto-repeat,
// a valid/ready drop request and player tracking. Define CURSOR_WRAP_EN for wrap-around edges.
module column_cursor #(
    parameter int NUM_COLS     = 7,
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 10_000_000
) (
    input  logic                CLOCK_50,
    input  logic                RESET,
    input  logic [1:0]          KEY_TWO,
    input  logic [NUM_COLS-1:0] COL_FULL,
    input  logic                DROP_READY,
    output logic [2:0]          CURSOR,
    output logic                DROP_VALID,
    output logic [2:0]          DROP_COL,
    output logic                PLAYER,
    output logic                ERR_FULL
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HOLD     = 3'd1,
        REPEAT   = 3'd2,
        DROP     = 3'd3,
        WAIT_REL = 3'd4
    } state_t;

    localparam logic [1:0]  CMD_NONE   = 2'b00;
    localparam logic [1:0]  CMD_RIGHT  = 2'b01;
    localparam logic [1:0]  CMD_LEFT   = 2'b10;
    localparam logic [1:0]  CMD_DROP   = 2'b11;
    localparam logic [2:0]  COL_MAX    = 3'(NUM_COLS - 1);
    localparam logic [2:0]  COL_HOME   = 3'(NUM_COLS / 2);
    localparam logic [25:0] DELAY_LAST = 26'(REPEAT_DELAY - 1);
    localparam logic [25:0] RATE_LAST  = 26'(REPEAT_RATE - 1);

    state_t      state_q, state_d;
    logic [1:0]  prev_q;
    logic [25:0] cnt_q, cnt_d;
    logic [2:0]  cursor_q, cursor_d;
    logic        valid_q, valid_d;
    logic [2:0]  col_q, col_d;
    logic        player_q, player_d;
    logic        err_q, err_d;

    logic        press;
    logic        repeat_due;
    logic [7:0]  full_pad;

    // Pad to 8 bits so a 3-bit cursor can index any legal column count.
    assign full_pad   = 8'(COL_FULL);
    assign press      = (KEY_TWO != prev_q) && (KEY_TWO != CMD_NONE);
    assign repeat_due = ((state_q == HOLD)   && (cnt_q == DELAY_LAST)) ||
                        ((state_q == REPEAT) && (cnt_q == RATE_LAST));

    function automatic logic [2:0] step_col(input logic [2:0] col, input logic [1:0] cmd);
        logic [2:0] res;
        res = col;
        if (cmd == CMD_RIGHT) begin
`ifdef CURSOR_WRAP_EN
            res = (col == COL_MAX) ? 3'd0 : col + 3'd1;
`else
            res = (col == COL_MAX) ? col : col + 3'd1;
`endif
        end else if (cmd == CMD_LEFT) begin
`ifdef CURSOR_WRAP_EN
            res = (col == 3'd0) ? COL_MAX : col - 3'd1;
`else
            res = (col == 3'd0) ? col : col - 3'd1;
`endif
        end
        return res;
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cursor_d = cursor_q;
        valid_d  = valid_q;
        col_d    = col_q;
        player_d = player_q;
        err_d    = 1'b0;

        case (state_q)
            IDLE, HOLD, REPEAT: begin
                if (press) begin
                    cnt_d = '0;
                    if (KEY_TWO == CMD_DROP) begin
                        // Fullness is judged only here; later changes cannot withdraw the request.
                        if (full_pad[cursor_q]) begin
                            err_d   = 1'b1;
                            state_d = WAIT_REL;
                        end else begin
                            valid_d = 1'b1;
                            col_d   = cursor_q;
                            state_d = DROP;
                        end
                    end else begin
                        cursor_d = step_col(cursor_q, KEY_TWO);
                        state_d  = HOLD;
                    end
                end else if (state_q != IDLE) begin
                    if (KEY_TWO == CMD_NONE) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else if (repeat_due) begin
                        cursor_d = step_col(cursor_q, KEY_TWO);
                        cnt_d    = '0;
                        state_d  = REPEAT;
                    end else begin
                        cnt_d = cnt_q + 26'd1;
                    end
                end
            end
            DROP: begin
                if (DROP_READY) begin
                    valid_d  = 1'b0;
                    player_d = ~player_q;
                    state_d  = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (KEY_TWO == CMD_NONE) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q  <= IDLE;
            prev_q   <= CMD_NONE;
            cnt_q    <= '0;
            cursor_q <= COL_HOME;
            valid_q  <= 1'b0;
            col_q    <= 3'd0;
            player_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= KEY_TWO;
            cnt_q    <= cnt_d;
            cursor_q <= cursor_d;
            valid_q  <= valid_d;
            col_q    <= col_d;
            player_q <= player_d;
            err_q    <= err_d;
        end
    end

    assign CURSOR     = cursor_q;
    assign DROP_VALID = valid_q;
    assign DROP_COL   = col_q;
    assign PLAYER     = player_q;
    assign ERR_FULL   = err_q;

endmodule
